// File: rtl/sa_pkg.sv
// Shared types and default sizes for the systolic-array result drain path.
package sa_pkg;

  localparam int SA_ROWS  = 8;
  localparam int SA_DEPTH = 4;
  localparam int SA_ACC_W = 32;

  typedef logic signed [SA_ACC_W-1:0] acc_t;
  typedef logic [$clog2(SA_ROWS)-1:0] row_idx_t;
  typedef acc_t [SA_ROWS-1:0]         res_vec_t;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } drain_state_e;

endpackage

// File: rtl/sa_vec_fifo.sv
// Small vector FIFO holding {result vector, row-valid mask}; exposes both the
// head entry and the entry behind it so the drain can reload without a bubble.
module sa_vec_fifo
  import sa_pkg::*;
#(
  parameter int ROWS  = SA_ROWS,
  parameter int DEPTH = SA_DEPTH,
  parameter int ACC_W = SA_ACC_W
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         push,
  input  logic [ROWS-1:0][ACC_W-1:0]   push_data,
  input  logic [ROWS-1:0]              push_mask,
  input  logic                         pop,
  output logic [ROWS-1:0][ACC_W-1:0]   head_data,
  output logic [ROWS-1:0]              head_mask,
  output logic [ROWS-1:0][ACC_W-1:0]   next_data,
  output logic [ROWS-1:0]              next_mask,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = ROWS * ACC_W + ROWS;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW-1:0] rd_next_ptr;
  logic [CW-1:0] count_reg;

  // Storage is not reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= {push_data, push_mask};
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign rd_next_ptr            = rd_ptr_reg + AW'(1);
  assign {head_data, head_mask} = mem[rd_ptr_reg];
  assign {next_data, next_mask} = mem[rd_next_ptr];
  assign full                   = (count_reg == CW'(DEPTH));
  assign empty                  = (count_reg == '0);
  assign count                  = count_reg;

endmodule

// File: rtl/sa_result_drain.sv
// Captures per-row result vectors from the array core and serialises the valid
// rows onto one word stream. Define SA_DRAIN_RELU_EN to clamp negative words to 0.
module sa_result_drain
  import sa_pkg::*;
#(
  parameter int ROWS  = SA_ROWS,
  parameter int DEPTH = SA_DEPTH,
  parameter int ACC_W = SA_ACC_W
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [ROWS-1:0][ACC_W-1:0]   rinport,
  input  logic [ROWS-1:0]              rvalidin,
  output logic                         outread,
  output logic [ACC_W-1:0]             out_data,
  output logic [$clog2(ROWS)-1:0]      out_row,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_last,
  output logic [$clog2(DEPTH):0]       fifo_count
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(DEPTH) + 1;

  drain_state_e                state_reg;
  logic                        full;
  logic                        empty;
  logic                        accept;
  logic                        pop;
  logic [ROWS-1:0][ACC_W-1:0]  head_data;
  logic [ROWS-1:0]             head_mask;
  logic [ROWS-1:0][ACC_W-1:0]  next_data;
  logic [ROWS-1:0]             next_mask;
  logic [ROWS-1:0][ACC_W-1:0]  ld_data;
  logic [ROWS-1:0]             ld_mask;
  logic [RW-1:0]               ld_ptr;
  logic [RW-1:0]               cont_ptr;

  function automatic logic [RW-1:0] first_set(input logic [ROWS-1:0] m, input int from);
    logic [RW-1:0] r;
    r = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (i >= from && m[i]) r = RW'(i);
    end
    return r;
  endfunction

  function automatic logic any_above(input logic [ROWS-1:0] m, input logic [RW-1:0] idx);
    logic a;
    a = 1'b0;
    for (int i = 0; i < ROWS; i++) begin
      if (i > int'(idx) && m[i]) a = 1'b1;
    end
    return a;
  endfunction

  function automatic logic [ACC_W-1:0] out_word(input logic [ACC_W-1:0] w);
`ifdef SA_DRAIN_RELU_EN
    return w[ACC_W-1] ? '0 : w;
`else
    return w;
`endif
  endfunction

  // Full is taken from the registered count, so a slot freed this cycle is only offered next cycle.
  assign outread = rstn & (|rvalidin) & ~full;
  assign accept  = out_valid & out_ready;
  assign pop     = (state_reg == EMIT) & accept & out_last;

  sa_vec_fifo #(
    .ROWS  (ROWS),
    .DEPTH (DEPTH),
    .ACC_W (ACC_W)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (outread),
    .push_data (rinport),
    .push_mask (rvalidin),
    .pop       (pop),
    .head_data (head_data),
    .head_mask (head_mask),
    .next_data (next_data),
    .next_mask (next_mask),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count)
  );

  // A fresh load comes from the head when idle, or from the entry behind it when the head is being popped.
  always_comb begin
    ld_data = head_data;
    ld_mask = head_mask;
    if (state_reg == EMIT) begin
      ld_data = next_data;
      ld_mask = next_mask;
    end
  end

  assign ld_ptr   = first_set(ld_mask, 0);
  assign cont_ptr = first_set(head_mask, int'(out_row) + 1);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg <= IDLE;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_row   <= '0;
      out_data  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (!empty) begin
            state_reg <= EMIT;
            out_valid <= 1'b1;
            out_row   <= ld_ptr;
            out_data  <= out_word(ld_data[ld_ptr]);
            out_last  <= ~any_above(ld_mask, ld_ptr);
          end
        end
        EMIT: begin
          if (accept) begin
            if (!out_last) begin
              out_row  <= cont_ptr;
              out_data <= out_word(head_data[cont_ptr]);
              out_last <= ~any_above(head_mask, cont_ptr);
            end else if (fifo_count > CW'(1)) begin
              out_row  <= ld_ptr;
              out_data <= out_word(ld_data[ld_ptr]);
              out_last <= ~any_above(ld_mask, ld_ptr);
            end else begin
              state_reg <= IDLE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
